// File: rtl/uart_reg_bank.sv
// Memory-mapped register bank for the UART block: RW, read-only (live hw_in) and
// write-1-to-clear (sticky hw set) registers behind a valid/ready request port.
module uart_reg_bank #(
  parameter int unsigned             ADDR_WIDTH = 32,
  parameter int unsigned             DATA_WIDTH = 32,
  parameter int unsigned             NUM_REGS   = 8,
  parameter logic [ADDR_WIDTH-1:0]   BASE_ADDR  = 32'h4000_C000,
  parameter logic [NUM_REGS-1:0]     RO_MASK    = '0,
  parameter logic [NUM_REGS-1:0]     W1C_MASK   = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ADDR_WIDTH-1:0]          addr,
  input  logic                           wr_en,
  input  logic                           valid,
  output logic                           ready,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [DATA_WIDTH/8-1:0]        wstrb,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_in,
  output logic                           resp_valid,
  output logic                           resp_err,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out
);

  localparam int unsigned NB   = DATA_WIDTH / 8;
  localparam int unsigned IDXW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(4 * NUM_REGS);

  typedef enum logic {IDLE, RESP} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  resp_err_q, resp_err_d;

  logic [ADDR_WIDTH-1:0] off;
  logic [IDXW-1:0]       idx;
  logic                  hit;
  logic                  accept;
  logic [DATA_WIDTH-1:0] bmask;
  logic [DATA_WIDTH-1:0] rd_val;
  logic                  sel_ro;
  logic                  unused_hw;

  // Addresses below BASE_ADDR wrap to a huge offset and so fall outside SPAN.
  assign off    = addr - BASE_ADDR;
  assign idx    = off[IDXW+1:2];
  assign hit    = (off < SPAN) && (off[1:0] == 2'b00);
  assign accept = valid && (state_q == IDLE);

  // hw_in slices of RW registers are intentionally ignored.
  assign unused_hw = ^hw_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (valid) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready      = (state_q == IDLE);
    resp_valid = (state_q == RESP);
  end

  always_comb begin
    bmask = '0;
    for (int unsigned b = 0; b < NB; b++) bmask[8*b +: 8] = {8{wstrb[b]}};
  end

  always_comb begin
    rd_val = '0;
    sel_ro = 1'b0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (hit && (idx == IDXW'(i))) begin
        sel_ro = RO_MASK[i];
        rd_val = RO_MASK[i] ? hw_in[i*DATA_WIDTH +: DATA_WIDTH] : regs_q[i];
      end
    end
  end

  // Hardware set is OR-ed in after the software clear so a coincident set wins.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (RO_MASK[i]) begin
        regs_d[i] = '0;
      end else begin
        if (accept && wr_en && hit && (idx == IDXW'(i))) begin
          regs_d[i] = W1C_MASK[i] ? (regs_q[i] & ~(wdata & bmask))
                                  : ((regs_q[i] & ~bmask) | (wdata & bmask));
        end
        if (W1C_MASK[i]) regs_d[i] = regs_d[i] | hw_in[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    rdata_d    = rdata_q;
    resp_err_d = resp_err_q;
    if (accept) begin
      resp_err_d = !hit || (wr_en && sel_ro);
      rdata_d    = (hit && !wr_en) ? rd_val : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      rdata_q    <= '0;
      resp_err_q <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      rdata_q    <= rdata_d;
      resp_err_q <= resp_err_d;
    end
  end

  assign rdata    = rdata_q;
  assign resp_err = resp_err_q;

  always_comb begin
    reg_out = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      reg_out[i*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[i] ? hw_in[i*DATA_WIDTH +: DATA_WIDTH]
                                                       : regs_q[i];
    end
  end

endmodule

// File: tb/tb_uart_reg_bank.sv
// Bench for uart_reg_bank: per-cycle comparison against a behavioural register-map
// model, plus directed transactions with hand-computed expected values.
module tb_uart_reg_bank;

  localparam int unsigned NR   = 8;
  localparam logic [31:0] BASE = 32'h4000_C000;
  localparam logic [NR-1:0] RO  = 8'h10;
  localparam logic [NR-1:0] W1C = 8'h04;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [31:0]    addr = '0;
  logic           wr_en = 1'b0;
  logic           valid = 1'b0;
  logic           ready;
  logic [31:0]    wdata = '0;
  logic [3:0]     wstrb = '0;
  logic [NR*32-1:0] hw_in;
  logic           resp_valid;
  logic           resp_err;
  logic [31:0]    rdata;
  logic [NR*32-1:0] reg_out;

  logic [31:0] hw [NR];
  int n_checks = 0;
  int n_fail   = 0;
  int unsigned last_wait;

  // model state
  logic [31:0] m [NR];
  logic        m_busy  = 1'b0;
  logic        m_err   = 1'b0;
  logic [31:0] m_rdata = '0;

  uart_reg_bank #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .NUM_REGS  (NR),
    .BASE_ADDR (BASE),
    .RO_MASK   (RO),
    .W1C_MASK  (W1C)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .wr_en     (wr_en),
    .valid     (valid),
    .ready     (ready),
    .wdata     (wdata),
    .wstrb     (wstrb),
    .hw_in     (hw_in),
    .resp_valid(resp_valid),
    .resp_err  (resp_err),
    .rdata     (rdata),
    .reg_out   (reg_out)
  );

  always #5 clk = ~clk;

  always_comb begin
    hw_in = '0;
    for (int i = 0; i < NR; i++) hw_in[i*32 +: 32] = hw[i];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Register-map model: decode by plain arithmetic, reads see the pre-edge value.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0; m_err = 1'b0; m_rdata = '0;
      for (int i = 0; i < NR; i++) m[i] = '0;
    end else begin
      if (!m_busy && valid) begin
        logic [31:0] off;
        int unsigned r;
        logic h;
        off = addr - BASE;
        h   = (off < 4 * NR) && ((off % 4) == 0);
        r   = off / 4;
        if (!wr_en) begin
          m_err   = !h;
          m_rdata = !h ? 32'h0 : (RO[r] ? hw[r] : m[r]);
        end else begin
          m_rdata = '0;
          m_err   = !h || RO[r];
          if (h && !RO[r]) begin
            for (int b = 0; b < 4; b++) begin
              if (wstrb[b]) begin
                if (W1C[r]) m[r][8*b +: 8] = m[r][8*b +: 8] & ~wdata[8*b +: 8];
                else        m[r][8*b +: 8] = wdata[8*b +: 8];
              end
            end
          end
        end
        m_busy = 1'b1;
      end else begin
        m_busy = 1'b0;
      end
      for (int i = 0; i < NR; i++) if (W1C[i]) m[i] = m[i] | hw[i];
    end
  end

  always @(negedge clk) begin
    chk("ready", ready, !m_busy);
    chk("resp_valid", resp_valid, m_busy);
    chk("rdata", rdata, m_rdata);
    if (m_busy) chk("resp_err", resp_err, m_err);
    for (int i = 0; i < NR; i++)
      chk($sformatf("reg_out[%0d]", i), reg_out[i*32 +: 32], RO[i] ? hw[i] : m[i]);
  end

  task automatic txn(input logic [31:0] a, input logic w, input logic [31:0] d,
                     input logic [3:0] s, output logic e, output logic [31:0] r);
    int unsigned cyc;
    logic acc;
    #2;
    addr = a; wr_en = w; wdata = d; wstrb = s; valid = 1'b1;
    cyc = 0; acc = 1'b0;
    while (cyc < 20) begin
      acc = ready;
      @(posedge clk);
      cyc++;
      if (acc) break;
      #1;
    end
    #1 valid = 1'b0;
    last_wait = cyc;
    chk("accept_timeout", acc, 1'b1);
    @(negedge clk);
    chk("resp_one_after_accept", resp_valid, 1'b1);
    e = resp_err;
    r = rdata;
    @(negedge clk);
    chk("resp_single_cycle", resp_valid, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        e;
    logic [31:0] r;
    int          nresp;
    int          nready;
    for (int i = 0; i < NR; i++) hw[i] = 32'hDEAD_0000 + i;
    hw[2] = 32'h0;
    hw[4] = 32'h1357_9BDF;

    #8;
    chk("rst_ready", ready, 1'b1);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_err", resp_err, 1'b0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_reg0", reg_out[31:0], 32'h0);
    #4 rst = 1'b0;

    txn(32'h4000_C000, 1'b1, 32'hA5A5_1234, 4'hF, e, r);
    chk("first_edge_accept", last_wait, 1);
    chk("wr0_err", e, 1'b0);
    chk("wr0_rdata", r, 32'h0);
    txn(32'h4000_C000, 1'b0, 32'h0, 4'h0, e, r);
    chk("rd0_err", e, 1'b0);
    chk("rd0_data", r, 32'hA5A5_1234);

    txn(32'h4000_C004, 1'b1, 32'h1122_3344, 4'hF, e, r);
    txn(32'h4000_C004, 1'b1, 32'hFFFF_FFFF, 4'b0101, e, r);
    txn(32'h4000_C004, 1'b0, 32'h0, 4'h0, e, r);
    chk("strb_data", r, 32'h11FF_33FF);
    txn(32'h4000_C004, 1'b1, 32'h0000_0000, 4'h0, e, r);
    chk("strb0_err", e, 1'b0);
    txn(32'h4000_C004, 1'b0, 32'h0, 4'h0, e, r);
    chk("strb0_data", r, 32'h11FF_33FF);

    #2 hw[2] = 32'hF;
    @(posedge clk); #1 hw[2] = 32'h0;
    txn(32'h4000_C008, 1'b0, 32'h0, 4'h0, e, r);
    chk("w1c_set", r, 32'hF);
    txn(32'h4000_C008, 1'b1, 32'h5, 4'hF, e, r);
    chk("w1c_wr_err", e, 1'b0);
    txn(32'h4000_C008, 1'b0, 32'h0, 4'h0, e, r);
    chk("w1c_clear", r, 32'hA);
    #2 hw[2] = 32'hF;
    @(posedge clk); #1 hw[2] = 32'h1;
    txn(32'h4000_C008, 1'b1, 32'h5, 4'hF, e, r);
    txn(32'h4000_C008, 1'b0, 32'h0, 4'h0, e, r);
    chk("w1c_set_wins", r, 32'hB);
    #2 hw[2] = 32'h0;
    txn(32'h4000_C008, 1'b0, 32'h0, 4'h0, e, r);
    chk("w1c_sticky", r, 32'hB);

    txn(32'h4000_C010, 1'b0, 32'h0, 4'h0, e, r);
    chk("ro_rd_err", e, 1'b0);
    chk("ro_rd_data", r, 32'h1357_9BDF);
    txn(32'h4000_C002, 1'b0, 32'h0, 4'h0, e, r);
    chk("miss_unaligned_err", e, 1'b1);
    chk("miss_unaligned_data", r, 32'h0);
    txn(32'h4000_C020, 1'b0, 32'h0, 4'h0, e, r);
    chk("miss_top_err", e, 1'b1);
    chk("miss_top_data", r, 32'h0);
    txn(32'h4000_BFFC, 1'b0, 32'h0, 4'h0, e, r);
    chk("miss_below_err", e, 1'b1);
    txn(32'h4000_C010, 1'b1, 32'hFFFF_FFFF, 4'hF, e, r);
    chk("ro_wr_err", e, 1'b1);
    chk("ro_wr_data", r, 32'h0);
    txn(32'h4000_C020, 1'b1, 32'hFFFF_FFFF, 4'hF, e, r);
    chk("miss_wr_err", e, 1'b1);
    chk("err_keep_reg0", reg_out[31:0], 32'hA5A5_1234);
    chk("err_keep_reg1", reg_out[63:32], 32'h11FF_33FF);

    #2 addr = 32'h4000_C000; wr_en = 1'b0; valid = 1'b1;
    nresp = 0; nready = 0;
    repeat (8) begin
      @(negedge clk);
      nresp  += int'(resp_valid);
      nready += int'(ready);
    end
    valid = 1'b0;
    chk("hold_valid_resps", nresp, 4);
    chk("hold_valid_ready", nready, 4);

    #2 addr = 32'h4000_C004; valid = 1'b1;
    @(posedge clk); #1 valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("midrst_resp_valid", resp_valid, 1'b0);
    chk("midrst_ready", ready, 1'b1);
    chk("midrst_rdata", rdata, 32'h0);
    chk("midrst_reg0", reg_out[31:0], 32'h0);
    chk("midrst_reg1", reg_out[63:32], 32'h0);
    chk("midrst_reg2", reg_out[95:64], 32'h0);
    @(negedge clk); @(posedge clk); @(negedge clk);
    #2 rst = 1'b0;
    nresp = 0;
    repeat (3) begin
      @(negedge clk);
      nresp += int'(resp_valid);
    end
    chk("no_stale_resp", nresp, 0);
    txn(32'h4000_C004, 1'b0, 32'h0, 4'h0, e, r);
    chk("post_rst_err", e, 1'b0);
    chk("post_rst_data", r, 32'h0);

    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
